// File: rtl/drum_pkg.sv
// Shared types and constants for the percussion voice and its sine table.
package drum_pkg;

  localparam int unsigned SINE_W      = 10;
  localparam int unsigned SINE_ADDR_W = 8;
  localparam int unsigned SINE_MID    = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DECAY = 2'd1,
    ST_CHOKE = 2'd2
  } state_t;

endpackage

// File: rtl/sine_rom.sv
// Combinational 256-entry sine table, offset binary around SINE_MID.
// Each half-wave is the parabola x*(128-x)/8, clamped to +/-511.
module sine_rom
  import drum_pkg::*;
(
  input  logic [SINE_ADDR_W-1:0] i_addr,
  output logic [SINE_W-1:0]      o_sine_val
);

  logic [6:0]  w_x;
  logic [13:0] w_y;
  logic [8:0]  w_mag;

  assign w_x   = i_addr[6:0];
  assign w_y   = 14'(w_x) * (14'd128 - 14'(w_x));
  assign w_mag = (w_y >= 14'd4088) ? 9'd511 : 9'(w_y >> 3);

  assign o_sine_val = i_addr[SINE_ADDR_W-1] ? (SINE_W'(SINE_MID) - SINE_W'(w_mag))
                                            : (SINE_W'(SINE_MID) + SINE_W'(w_mag));

endmodule

// File: rtl/perc_voice.sv
// One-shot percussion voice: pitch-swept sine oscillator with linear gain
// decay, fast choke fade and a two-stage registered gain multiply.
module perc_voice
  import drum_pkg::*;
#(
  parameter int unsigned OUT_W        = 10,
  parameter int unsigned GAIN_W       = 10,
  parameter int unsigned PHASE_W      = 16,
  parameter int unsigned DIV_W        = 6,
  parameter int unsigned START_PHASE  = 20000,
  parameter int unsigned RETRIG_PHASE = 1,
  parameter int unsigned CHOKE_STEP   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic               trigger,
  input  logic               choke,
  input  logic [GAIN_W-1:0]  velocity,
  input  logic [PHASE_W-1:0] pitch_base,
  input  logic [PHASE_W-1:0] pitch_attack,
  input  logic [PHASE_W-1:0] pitch_step,
  input  logic [DIV_W-1:0]   pitch_div,
  input  logic [DIV_W-1:0]   decay_div,
  output logic [OUT_W-1:0]   out,
  output logic               active
);

  localparam int unsigned PROD_W  = SINE_W + 1 + GAIN_W;
  localparam int unsigned SHIFT   = GAIN_W + SINE_W - OUT_W;
  localparam logic [OUT_W-1:0] OUT_MID = OUT_W'(1) << (OUT_W - 1);

  state_t                     r_state, w_state_nxt;
  logic [PHASE_W-1:0]         r_phase, w_phase_nxt;
  logic [PHASE_W-1:0]         r_pitch_env, w_env_nxt;
  logic [GAIN_W-1:0]          r_gain, w_gain_nxt, w_gain_choke;
  logic [DIV_W-1:0]           r_pdiv, w_pdiv_nxt;
  logic [DIV_W-1:0]           r_gdiv, w_gdiv_nxt;
  logic                       r_trig_d;
  logic signed [PROD_W-1:0]   r_product, w_product;
  logic signed [SINE_W:0]     w_s;
  logic [SINE_W-1:0]          w_sine;
  logic [OUT_W-1:0]           r_out;
  logic                       r_active;
  logic                       w_hit;

  assign w_hit        = trigger && !r_trig_d && (velocity != '0);
  assign w_gain_choke = (r_gain > GAIN_W'(CHOKE_STEP)) ? (r_gain - GAIN_W'(CHOKE_STEP)) : '0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_state <= ST_IDLE;
    else if (sample_tick) r_state <= w_state_nxt;
  end

  // Next state: a velocity-qualified rising edge always wins
  always_comb begin
    w_state_nxt = r_state;
    if (w_hit) begin
      w_state_nxt = ST_DECAY;
    end else begin
      case (r_state)
        ST_DECAY: begin
          if (w_gain_nxt == '0) w_state_nxt = ST_IDLE;
          else if (choke)       w_state_nxt = ST_CHOKE;
        end
        ST_CHOKE: if (w_gain_nxt == '0) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Envelope outputs; a choke seen in DECAY already fades on that tick
  always_comb begin
    w_gain_nxt = r_gain;
    w_env_nxt  = r_pitch_env;
    w_pdiv_nxt = r_pdiv;
    w_gdiv_nxt = r_gdiv;
    if (w_hit) begin
      w_gain_nxt = velocity;
      w_env_nxt  = pitch_attack;
      w_pdiv_nxt = '0;
      w_gdiv_nxt = '0;
    end else begin
      case (r_state)
        ST_DECAY: begin
          if (choke) begin
            w_gain_nxt = w_gain_choke;
          end else begin
            if (r_pitch_env != '0) begin
              if (r_pdiv == pitch_div) begin
                w_pdiv_nxt = '0;
                w_env_nxt  = (r_pitch_env > pitch_step) ? (r_pitch_env - pitch_step) : '0;
              end else begin
                w_pdiv_nxt = r_pdiv + DIV_W'(1);
              end
            end
            if (r_gdiv == decay_div) begin
              w_gdiv_nxt = '0;
              w_gain_nxt = r_gain - GAIN_W'(1);
            end else begin
              w_gdiv_nxt = r_gdiv + DIV_W'(1);
            end
          end
        end
        ST_CHOKE: w_gain_nxt = w_gain_choke;
        default: begin
          w_gain_nxt = '0;
          w_env_nxt  = '0;
          w_pdiv_nxt = '0;
          w_gdiv_nxt = '0;
        end
      endcase
    end
  end

  assign w_phase_nxt = (w_hit && (RETRIG_PHASE != 0)) ? PHASE_W'(START_PHASE)
                                                      : (r_phase + pitch_base + r_pitch_env);

  sine_rom u_sine_rom (
    .i_addr     (r_phase[PHASE_W-1 -: SINE_ADDR_W]),
    .o_sine_val (w_sine)
  );

  assign w_s       = $signed({1'b0, w_sine}) - $signed((SINE_W + 1)'(SINE_MID));
  assign w_product = PROD_W'(w_s) * PROD_W'($signed({1'b0, r_gain}));

  // Datapath and output registers, advanced only on sample ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase     <= '0;
      r_pitch_env <= '0;
      r_gain      <= '0;
      r_pdiv      <= '0;
      r_gdiv      <= '0;
      r_trig_d    <= 1'b0;
      r_product   <= '0;
      r_out       <= OUT_MID;
      r_active    <= 1'b0;
    end else if (sample_tick) begin
      r_phase     <= w_phase_nxt;
      r_pitch_env <= w_env_nxt;
      r_gain      <= w_gain_nxt;
      r_pdiv      <= w_pdiv_nxt;
      r_gdiv      <= w_gdiv_nxt;
      r_trig_d    <= trigger;
      r_product   <= w_product;
      r_out       <= OUT_MID + OUT_W'(r_product >>> SHIFT);
      r_active    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign out    = r_out;
  assign active = r_active;

endmodule
